systolic_feeder: RTL and testbench

- Initiator side of the PE operand interface.
- Holds an NxN A matrix and an NxN B matrix loaded through a simple write port.
- On start, streams the matrices into the west and north edges of an NxN PE array, skewed diagonally and zero-padded.
- Sits between the PCPI command decoder and the PE grid; each output lane drives one edge PE's a_in/b_in.

---
 rtl/systolic_feeder.sv | 191 +++++++++++++++++++
 tb/tb_systolic_feeder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder
//
// Initiator side of the PE operand interface. Holds an NxN A matrix and an
// NxN B matrix written through a simple write port. On start it streams them
// into the west (A rows) and north (B columns) edges of an NxN PE array,
// diagonally skewed and zero padded. A run of zero cycles follows so the
// array can flush, then done pulses for one cycle.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset (aborts any run, clears storage)
//   wr_en_i       operand write strobe (honoured in IDLE only)
//   wr_sel_i      0 = write A, 1 = write B
//   wr_addr_i     {row, col}, row in the upper half
//   wr_data_i     signed operand value
//   start_i       begin streaming (sampled in IDLE only, wins over wr_en_i)
//   a_row_out_o   lane i drives PE row i a_in
//   b_col_out_o   lane j drives PE column j b_in
//   feed_valid_o  high while feed steps 0..2N-2 are on the lanes
//   busy_o        high during FEED and DRAIN
//   done_o        one-cycle pulse once the drain has completed
// ---------------------------------------------------------------------------
module systolic_feeder #(
    parameter int N            = 2,
    parameter int DATA_W       = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic                     wr_sel_i,
    input  logic [2*$clog2(N)-1:0]   wr_addr_i,
    input  logic signed [DATA_W-1:0] wr_data_i,
    input  logic                     start_i,
    output logic [N*DATA_W-1:0]      a_row_out_o,
    output logic [N*DATA_W-1:0]      b_col_out_o,
    output logic                     feed_valid_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int AW   = $clog2(N);
    // The step counter is shared between the feed steps and the drain cycles,
    // so it must hold whichever count is larger.
    localparam int MAXC = (2*N > DRAIN_CYCLES + 1) ? 2*N : DRAIN_CYCLES + 1;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] FEED_LAST  = CW'(2*N - 2);
    localparam logic [CW-1:0] DRAIN_LAST = (DRAIN_CYCLES > 0) ? CW'(DRAIN_CYCLES - 1) : '0;
    localparam logic [CW-1:0] N_CW       = CW'(N);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } state_t;

    state_t                   state_q;
    logic [CW-1:0]            stepCnt_q;
    logic signed [DATA_W-1:0] aMem_q [N][N];
    logic signed [DATA_W-1:0] bMem_q [N][N];
    logic [N*DATA_W-1:0]      aRow_q;
    logic [N*DATA_W-1:0]      bCol_q;
    logic                     feedValid_q;
    logic                     busy_q;
    logic                     done_q;

    logic [CW-1:0]            nextStep_d;
    logic [N*DATA_W-1:0]      aRow_d;
    logic [N*DATA_W-1:0]      bCol_d;
    logic [AW-1:0]            wrRow;
    logic [AW-1:0]            wrCol;
    logic                     inRange;

    assign wrRow = wr_addr_i[2*AW-1:AW];
    assign wrCol = wr_addr_i[AW-1:0];

    // With a power-of-two N every address decodes to a real cell; otherwise
    // rows/columns past N-1 must be dropped.
    if ((1 << AW) == N) begin : gPow2
        assign inRange = 1'b1;
    end else begin : gNonPow2
        localparam logic [AW-1:0] N_AW = AW'(N);
        assign inRange = (wrRow < N_AW) && (wrCol < N_AW);
    end

    // Step whose lane values get loaded at the coming clock edge: step 0 when
    // launching from IDLE, otherwise the one after the step now on the lanes.
    assign nextStep_d = (state_q == IDLE) ? '0 : stepCnt_q + CW'(1);

    // Skewed lane selection. Lane i carries element (step - i) of its row or
    // column. When step < i the subtraction wraps to a value far above N
    // (the counter has headroom past 2N), so a single "< N" test covers both
    // edges of the diagonal window.
    for (genvar i = 0; i < N; i++) begin : gLane
        localparam logic [CW-1:0] IDX = CW'(i);
        logic [CW-1:0] offs;
        logic          inWin;

        assign offs  = nextStep_d - IDX;
        assign inWin = (offs < N_CW);
        assign aRow_d[i*DATA_W +: DATA_W] = inWin ? aMem_q[i][offs[AW-1:0]] : '0;
        assign bCol_d[i*DATA_W +: DATA_W] = inWin ? bMem_q[offs[AW-1:0]][i] : '0;
    end

    // Sequencer, operand storage and registered outputs. Storage only changes
    // in IDLE, so a re-start always replays the same matrices. Lane values
    // for a step are registered on the edge before that step's cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            stepCnt_q   <= '0;
            aMem_q      <= '{default: '0};
            bMem_q      <= '{default: '0};
            aRow_q      <= '0;
            bCol_q      <= '0;
            feedValid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q     <= FEED;
                        stepCnt_q   <= '0;
                        aRow_q      <= aRow_d;
                        bCol_q      <= bCol_d;
                        feedValid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end else if (wr_en_i && inRange) begin
                        if (wr_sel_i) begin
                            bMem_q[wrRow][wrCol] <= wr_data_i;
                        end else begin
                            aMem_q[wrRow][wrCol] <= wr_data_i;
                        end
                    end
                end

                FEED: begin
                    if (stepCnt_q == FEED_LAST) begin
                        stepCnt_q   <= '0;
                        aRow_q      <= '0;
                        bCol_q      <= '0;
                        feedValid_q <= 1'b0;
                        if (DRAIN_CYCLES == 0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else begin
                        stepCnt_q <= nextStep_d;
                        aRow_q    <= aRow_d;
                        bCol_q    <= bCol_d;
                    end
                end

                DRAIN: begin
                    if (stepCnt_q == DRAIN_LAST) begin
                        state_q   <= DONE;
                        stepCnt_q <= '0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        stepCnt_q <= stepCnt_q + CW'(1);
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign a_row_out_o  = aRow_q;
    assign b_col_out_o  = bCol_q;
    assign feed_valid_o = feedValid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_feeder
//
// Drives two feeders: a 2x2 one with a 3-cycle drain and a 4x4 one with no
// drain. The bench keeps its own copy of the matrices, builds the expected
// lane/flag sequence for each run into a queue when start is driven, and pops
// one entry per cycle as the DUT produces output.
// ---------------------------------------------------------------------------
module tb_systolic_feeder;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        fv;
        logic        busy;
        logic        done;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        wrSel;
    logic [15:0] wrData;

    logic        wrEn2, start2;
    logic [1:0]  wrAddr2;
    logic [31:0] a2, b2;
    logic        fv2, busy2, done2;

    logic        wrEn4, start4;
    logic [3:0]  wrAddr4;
    logic [63:0] a4, b4;
    logic        fv4, busy4, done4;

    logic [15:0] mA [2][4][4];
    logic [15:0] mB [2][4][4];

    exp_t sbQ[$];
    int   checks = 0;
    int   fails  = 0;

    systolic_feeder #(.N(2), .DATA_W(16), .DRAIN_CYCLES(3)) dut2 (
        .clk(clk), .rst(rst),
        .wr_en_i(wrEn2), .wr_sel_i(wrSel), .wr_addr_i(wrAddr2), .wr_data_i(wrData),
        .start_i(start2),
        .a_row_out_o(a2), .b_col_out_o(b2),
        .feed_valid_o(fv2), .busy_o(busy2), .done_o(done2)
    );

    systolic_feeder #(.N(4), .DATA_W(16), .DRAIN_CYCLES(0)) dut4 (
        .clk(clk), .rst(rst),
        .wr_en_i(wrEn4), .wr_sel_i(wrSel), .wr_addr_i(wrAddr4), .wr_data_i(wrData),
        .start_i(start4),
        .a_row_out_o(a4), .b_col_out_o(b4),
        .feed_valid_o(fv4), .busy_o(busy4), .done_o(done4)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case something stalls the main sequence
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic exp_t getObs(input int id);
        exp_t o;
        if (id == 0) begin
            o.a = {32'b0, a2}; o.b = {32'b0, b2};
            o.fv = fv2; o.busy = busy2; o.done = done2;
        end else begin
            o.a = a4; o.b = b4;
            o.fv = fv4; o.busy = busy4; o.done = done4;
        end
        return o;
    endfunction

    task automatic compareEntry(input string tag, input exp_t o, input exp_t e);
        checkOutput({tag, ".a"},    o.a,           e.a);
        checkOutput({tag, ".b"},    o.b,           e.b);
        checkOutput({tag, ".fv"},   64'(o.fv),     64'(e.fv));
        checkOutput({tag, ".busy"}, 64'(o.busy),   64'(e.busy));
        checkOutput({tag, ".done"}, 64'(o.done),   64'(e.done));
    endtask

    task automatic clearModels();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    mA[d][r][c] = 16'h0;
                    mB[d][r][c] = 16'h0;
                end
    endtask

    task automatic setStart(input int id, input logic v);
        if (id == 0) start2 = v;
        else         start4 = v;
    endtask

    // One operand write performed while the DUT sits in IDLE
    task automatic loadOperand(input int id, input logic sel, input int row,
                               input int col, input logic [15:0] data);
        @(negedge clk);
        wrSel  = sel;
        wrData = data;
        if (id == 0) begin
            wrAddr2 = {row[0], col[0]};
            wrEn2   = 1'b1;
        end else begin
            wrAddr4 = {row[1:0], col[1:0]};
            wrEn4   = 1'b1;
        end
        if (sel) mB[id][row][col] = data;
        else     mA[id][row][col] = data;
        @(negedge clk);
        wrEn2 = 1'b0;
        wrEn4 = 1'b0;
    endtask

    // Expected sequence: skewed feed steps, drain zeros, done pulse, idle
    task automatic pushExpected(input int id, input int n, input int drain);
        exp_t e;
        for (int t = 0; t <= 2*n - 2; t++) begin
            e = '0;
            for (int i = 0; i < n; i++) begin
                int k = t - i;
                if (k >= 0 && k < n) begin
                    e.a[i*16 +: 16] = mA[id][i][k];
                    e.b[i*16 +: 16] = mB[id][k][i];
                end
            end
            e.fv = 1'b1; e.busy = 1'b1;
            sbQ.push_back(e);
        end
        for (int d = 0; d < drain; d++) begin
            e = '0; e.busy = 1'b1;
            sbQ.push_back(e);
        end
        e = '0; e.done = 1'b1;
        sbQ.push_back(e);
        e = '0;
        sbQ.push_back(e);
    endtask

    // mode 0: plain run
    // mode 1: write + start pulsed during FEED (must be ignored)
    // mode 2: write issued together with start in IDLE (write must be dropped)
    // mode 3: reset asserted during step 1
    // Every run also raises start in the DONE cycle, which must not restart.
    task automatic applyStimulus(input int id, input string tag, input int mode);
        int   n     = (id == 0) ? 2 : 4;
        int   drain = (id == 0) ? 3 : 0;
        int   idx   = 0;
        int   fvCount = 0, busyCount = 0, doneCycle = 0;
        exp_t e, o;

        pushExpected(id, n, drain);
        @(negedge clk);
        setStart(id, 1'b1);
        if (mode == 2) begin
            wrEn2 = 1'b1; wrSel = 1'b0; wrAddr2 = 2'b11; wrData = 16'd77;
        end
        @(negedge clk);
        setStart(id, 1'b0);
        wrEn2 = 1'b0;

        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            o = getObs(id);
            compareEntry($sformatf("%s[%0d]", tag, idx), o, e);
            if (o.fv)   fvCount++;
            if (o.busy) busyCount++;
            if (o.done && doneCycle == 0) doneCycle = idx + 1;

            setStart(id, e.done);
            if (mode == 1 && idx == 0) begin
                wrEn2 = 1'b1; wrSel = 1'b0; wrAddr2 = 2'b00; wrData = 16'd99;
                start2 = 1'b1;
            end else if (mode == 1 && idx == 1) begin
                wrEn2 = 1'b0;
            end

            if (mode == 3 && idx == 1) begin
                #1 rst = 1'b1;
                #1;
                o = getObs(id);
                e = '0;
                compareEntry({tag, ".async"}, o, e);
                sbQ.delete();
                clearModels();
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    o = getObs(id);
                    checkOutput($sformatf("%s.held%0d.done", tag, c), 64'(o.done), 64'd0);
                    checkOutput($sformatf("%s.held%0d.busy", tag, c), 64'(o.busy), 64'd0);
                end
                rst = 1'b0;
            end
            idx++;
            @(negedge clk);
        end

        if (mode == 0 && id == 1) begin
            checkOutput({tag, ".fvCycles"},   64'(fvCount),   64'd7);
            checkOutput({tag, ".busyCycles"}, 64'(busyCount), 64'd7);
            checkOutput({tag, ".doneCycle"},  64'(doneCycle), 64'd8);
        end
    endtask

    initial begin
        exp_t o;
        rst = 1'b1;
        wrSel = 1'b0; wrData = '0;
        wrEn2 = 1'b0; start2 = 1'b0; wrAddr2 = '0;
        wrEn4 = 1'b0; start4 = 1'b0; wrAddr4 = '0;
        clearModels();

        repeat (2) @(negedge clk);
        o = getObs(0);
        compareEntry("reset2", o, '0);
        o = getObs(1);
        compareEntry("reset4", o, '0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] basic skew");
        loadOperand(0, 1'b0, 0, 0, 16'd1);
        loadOperand(0, 1'b0, 0, 1, 16'd2);
        loadOperand(0, 1'b0, 1, 0, 16'd3);
        loadOperand(0, 1'b0, 1, 1, 16'd4);
        loadOperand(0, 1'b1, 0, 0, 16'd5);
        loadOperand(0, 1'b1, 0, 1, 16'd6);
        loadOperand(0, 1'b1, 1, 0, 16'd7);
        loadOperand(0, 1'b1, 1, 1, 16'd8);
        applyStimulus(0, "basic", 0);

        $display("[TB] lockout during feed, then replay");
        applyStimulus(0, "lockout", 1);
        applyStimulus(0, "replay", 0);

        $display("[TB] start together with write");
        applyStimulus(0, "simul", 2);

        $display("[TB] sign and width");
        loadOperand(0, 1'b0, 0, 0, 16'h8000);
        loadOperand(0, 1'b1, 1, 1, 16'hFFFF);
        applyStimulus(0, "sign", 0);

        $display("[TB] reset mid-feed");
        applyStimulus(0, "midrst", 3);
        applyStimulus(0, "cleared", 0);

        $display("[TB] 4x4 timing, no drain");
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                loadOperand(1, 1'b0, r, c, 16'(16'h0100 * r + c + 1));
                loadOperand(1, 1'b1, r, c, 16'(16'hF000 + 16 * r + c));
            end
        applyStimulus(1, "n4", 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
